// File: rtl/seq_binary_to_bcd.sv
// rtl/seq_binary_to_bcd.sv - iterative shift-and-add-3 binary to BCD converter, one bit per clock
// Optional macro BCD_SATURATE_EN: load all-nines into the BCD result on overflow.
module seq_binary_to_bcd #(
   parameter int BIN_WIDTH = 8,
   parameter int DIGITS    = 3
) (
   input  logic                    i_clk,
   input  logic                    i_rst_n,
   input  logic                    i_start,
   input  logic [BIN_WIDTH-1:0]    i_binary,
   output logic                    o_busy,
   output logic                    o_done,
   output logic [4*DIGITS-1:0]     o_bcd,
   output logic                    o_overflow
);

   localparam int BCD_W = 4 * DIGITS;
   localparam int CNT_W = $clog2(BIN_WIDTH + 1);

   typedef enum logic {IDLE, SHIFT} state_t;

   state_t               r_state,    w_state_nxt;
   logic [BIN_WIDTH-1:0] r_operand,  w_operand_nxt;
   logic [BCD_W-1:0]     r_scratch,  w_scratch_nxt;
   logic [CNT_W-1:0]     r_cnt,      w_cnt_nxt;
   logic                 r_sticky,   w_sticky_nxt;
   logic                 r_done,     w_done_nxt;
   logic [BCD_W-1:0]     r_bcd,      w_bcd_nxt;
   logic                 r_overflow, w_overflow_nxt;

   logic [BCD_W-1:0]     w_adj;
   logic [BCD_W-1:0]     w_shift_scratch;
   logic                 w_carry;
   logic                 w_last;
   logic                 w_ovf_final;
   logic [BCD_W-1:0]     w_result;

   always_comb begin
      w_adj = r_scratch;
      for (int d = 0; d < DIGITS; d++) begin
         if (r_scratch[4*d +: 4] >= 4'd5)
            w_adj[4*d +: 4] = r_scratch[4*d +: 4] + 4'd3;
      end
   end

   assign w_carry         = w_adj[BCD_W-1];
   assign w_shift_scratch = {w_adj[BCD_W-2:0], r_operand[BIN_WIDTH-1]};
   assign w_last          = (r_cnt == CNT_W'(BIN_WIDTH - 1));
   assign w_ovf_final     = r_sticky | w_carry;

`ifdef BCD_SATURATE_EN
   assign w_result = w_ovf_final ? {DIGITS{4'h9}} : w_shift_scratch;
`else
   assign w_result = w_shift_scratch;
`endif

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_state    <= IDLE;
         r_operand  <= '0;
         r_scratch  <= '0;
         r_cnt      <= '0;
         r_sticky   <= 1'b0;
         r_done     <= 1'b0;
         r_bcd      <= '0;
         r_overflow <= 1'b0;
      end else begin
         r_state    <= w_state_nxt;
         r_operand  <= w_operand_nxt;
         r_scratch  <= w_scratch_nxt;
         r_cnt      <= w_cnt_nxt;
         r_sticky   <= w_sticky_nxt;
         r_done     <= w_done_nxt;
         r_bcd      <= w_bcd_nxt;
         r_overflow <= w_overflow_nxt;
      end
   end

   always_comb begin
      w_state_nxt    = r_state;
      w_operand_nxt  = r_operand;
      w_scratch_nxt  = r_scratch;
      w_cnt_nxt      = r_cnt;
      w_sticky_nxt   = r_sticky;
      w_done_nxt     = 1'b0;
      w_bcd_nxt      = r_bcd;
      w_overflow_nxt = r_overflow;
      unique case (r_state)
         IDLE: begin
            // The Done cycle is spent in IDLE, so a Start there is accepted back-to-back.
            if (i_start) begin
               w_operand_nxt = i_binary;
               w_scratch_nxt = '0;
               w_sticky_nxt  = 1'b0;
               w_cnt_nxt     = '0;
               w_state_nxt   = SHIFT;
            end
         end
         SHIFT: begin
            w_operand_nxt = {r_operand[BIN_WIDTH-2:0], 1'b0};
            w_scratch_nxt = w_shift_scratch;
            w_sticky_nxt  = w_ovf_final;
            w_cnt_nxt     = r_cnt + CNT_W'(1);
            if (w_last) begin
               w_bcd_nxt      = w_result;
               w_overflow_nxt = w_ovf_final;
               w_done_nxt     = 1'b1;
               w_cnt_nxt      = '0;
               w_state_nxt    = IDLE;
            end
         end
         default: w_state_nxt = IDLE;
      endcase
   end

   assign o_busy     = (r_state == SHIFT);
   assign o_done     = r_done;
   assign o_bcd      = r_bcd;
   assign o_overflow = r_overflow;

endmodule

// File: tb/tb_seq_binary_to_bcd.sv
// tb/tb_seq_binary_to_bcd.sv - scoreboard bench for seq_binary_to_bcd in three configurations
module tb_seq_binary_to_bcd;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   logic        a_start, a_busy, a_done, a_ovf;
   logic [7:0]  a_bin;
   logic [11:0] a_bcd;
   logic        b_start, b_busy, b_done, b_ovf;
   logic [15:0] b_bin;
   logic [19:0] b_bcd;
   logic        c_start, c_busy, c_done, c_ovf;
   logic [7:0]  c_bin;
   logic [7:0]  c_bcd;

   seq_binary_to_bcd #(.BIN_WIDTH(8), .DIGITS(3)) u_a (
      .i_clk(clk), .i_rst_n(rst_n), .i_start(a_start), .i_binary(a_bin),
      .o_busy(a_busy), .o_done(a_done), .o_bcd(a_bcd), .o_overflow(a_ovf));
   seq_binary_to_bcd #(.BIN_WIDTH(16), .DIGITS(5)) u_b (
      .i_clk(clk), .i_rst_n(rst_n), .i_start(b_start), .i_binary(b_bin),
      .o_busy(b_busy), .o_done(b_done), .o_bcd(b_bcd), .o_overflow(b_ovf));
   seq_binary_to_bcd #(.BIN_WIDTH(8), .DIGITS(2)) u_c (
      .i_clk(clk), .i_rst_n(rst_n), .i_start(c_start), .i_binary(c_bin),
      .o_busy(c_busy), .o_done(c_done), .o_bcd(c_bcd), .o_overflow(c_ovf));

   typedef struct {
      logic [19:0] bcd;
      logic        ovf;
   } exp_t;

   exp_t qa[$];
   exp_t qb[$];
   exp_t qc[$];
   int   done_cyc[$];
   int   cyc = 0;
   int   checks = 0;
   int   failures = 0;

`ifdef BCD_SATURATE_EN
   localparam logic [19:0] C_OVF_BCD = 20'h99;
`else
   localparam logic [19:0] C_OVF_BCD = 20'h00;
`endif

   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%0h required=%0h", name, act, exp);
      end
   endtask

   task automatic unexpected(input string name);
      checks++;
      failures++;
      $display("FAIL %s actual=done required=no_done", name);
   endtask

   // Monitor: pops one expectation per Done pulse on each instance.
   always @(negedge clk) begin
      exp_t e;
      if (a_done) begin
         done_cyc.push_back(cyc);
         chk("a_busy_with_done", {31'd0, a_busy}, 32'd0);
         if (qa.size() == 0) unexpected("a_unexpected_done");
         else begin
            e = qa.pop_front();
            chk("a_bcd", {20'd0, a_bcd}, {12'd0, e.bcd});
            chk("a_ovf", {31'd0, a_ovf}, {31'd0, e.ovf});
         end
      end
      if (b_done) begin
         if (qb.size() == 0) unexpected("b_unexpected_done");
         else begin
            e = qb.pop_front();
            chk("b_bcd", {12'd0, b_bcd}, {12'd0, e.bcd});
            chk("b_ovf", {31'd0, b_ovf}, {31'd0, e.ovf});
         end
      end
      if (c_done) begin
         if (qc.size() == 0) unexpected("c_unexpected_done");
         else begin
            e = qc.pop_front();
            chk("c_bcd", {24'd0, c_bcd}, {12'd0, e.bcd});
            chk("c_ovf", {31'd0, c_ovf}, {31'd0, e.ovf});
         end
      end
   end

   task automatic wait_drain(input string name);
      int k = 0;
      while ((qa.size() + qb.size() + qc.size()) != 0 && k < 40) begin
         @(posedge clk);
         k++;
      end
      chk(name, qa.size() + qb.size() + qc.size(), 0);
      @(posedge clk); #1;
   endtask

   task automatic run_a(input logic [7:0] v, input logic [19:0] e, input logic o);
      qa.push_back('{bcd: e, ovf: o});
      a_bin = v; a_start = 1'b1;
      @(posedge clk); #1;
      a_start = 1'b0; a_bin = ~v;
      wait_drain("a_drain");
   endtask

   task automatic run_b(input logic [15:0] v, input logic [19:0] e, input logic o);
      qb.push_back('{bcd: e, ovf: o});
      b_bin = v; b_start = 1'b1;
      @(posedge clk); #1;
      b_start = 1'b0; b_bin = ~v;
      wait_drain("b_drain");
   endtask

   task automatic run_c(input logic [7:0] v, input logic [19:0] e, input logic o);
      qc.push_back('{bcd: e, ovf: o});
      c_bin = v; c_start = 1'b1;
      @(posedge clk); #1;
      c_start = 1'b0; c_bin = ~v;
      wait_drain("c_drain");
   endtask

   initial begin
      a_start = 0; a_bin = 0; b_start = 0; b_bin = 0; c_start = 0; c_bin = 0;
      repeat (2) @(posedge clk);
      #1;
      chk("rst_busy", {31'd0, a_busy}, 32'd0);
      chk("rst_done", {31'd0, a_done}, 32'd0);
      chk("rst_bcd", {20'd0, a_bcd}, 32'd0);
      chk("rst_ovf", {31'd0, a_ovf}, 32'd0);
      rst_n = 1'b1;
      @(posedge clk); #1;

      // Latency: Start at edge 0, Busy through edge 7, Done after edge 8.
      qa.push_back('{bcd: 20'h255, ovf: 1'b0});
      a_bin = 8'd255; a_start = 1'b1;
      @(posedge clk); #1;
      a_start = 1'b0; a_bin = 8'h5A;
      chk("lat_busy_e0", {31'd0, a_busy}, 32'd1);
      for (int i = 1; i <= 7; i++) begin
         @(posedge clk); #1;
         chk("lat_busy", {31'd0, a_busy}, 32'd1);
         chk("lat_no_done", {31'd0, a_done}, 32'd0);
      end
      @(posedge clk); #1;
      chk("lat_done_e8", {31'd0, a_done}, 32'd1);
      chk("lat_idle_e8", {31'd0, a_busy}, 32'd0);
      wait_drain("lat_drain");

      run_a(8'd0,   20'h000, 1'b0);
      run_a(8'd100, 20'h100, 1'b0);
      run_b(16'd65535, 20'h65535, 1'b0);
      run_b(16'd10000, 20'h10000, 1'b0);
      run_c(8'd99,  20'h99, 1'b0);
      run_c(8'd100, C_OVF_BCD, 1'b1);
      run_c(8'd200, C_OVF_BCD, 1'b1);
      chk("c_ovf_hold", {31'd0, c_ovf}, 32'd1);

      // A Start pulse while busy must be dropped, not queued.
      qa.push_back('{bcd: 20'h045, ovf: 1'b0});
      a_bin = 8'd45; a_start = 1'b1;
      @(posedge clk); #1;
      a_start = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      a_bin = 8'd77; a_start = 1'b1;
      @(posedge clk); #1;
      a_start = 1'b0;
      wait_drain("busy_start_drain");
      repeat (12) @(posedge clk);
      #1;

      // Start held high with Binary changing every cycle: accepts at 0, 9, 18.
      done_cyc.delete();
      for (int c = 0; c < 27; c++) begin
         a_bin = (c == 0) ? 8'd123 : (c == 9) ? 8'd7 : (c == 18) ? 8'd250 : 8'(c + 100);
         a_start = 1'b1;
         if (c == 0) qa.push_back('{bcd: 20'h123, ovf: 1'b0});
         if (c == 9) qa.push_back('{bcd: 20'h007, ovf: 1'b0});
         if (c == 18) qa.push_back('{bcd: 20'h250, ovf: 1'b0});
         @(posedge clk); #1;
      end
      a_start = 1'b0;
      wait_drain("b2b_drain");
      repeat (12) @(posedge clk);
      #1;
      chk("b2b_done_count", done_cyc.size(), 3);
      if (done_cyc.size() == 3) begin
         chk("b2b_period1", done_cyc[1] - done_cyc[0], 9);
         chk("b2b_period2", done_cyc[2] - done_cyc[1], 9);
      end

      // Reset after four shift steps aborts without Done.
      a_bin = 8'd200; a_start = 1'b1;
      @(posedge clk); #1;
      a_start = 1'b0;
      repeat (4) @(posedge clk);
      #1;
      rst_n = 1'b0;
      #1;
      chk("abort_busy", {31'd0, a_busy}, 32'd0);
      chk("abort_done", {31'd0, a_done}, 32'd0);
      chk("abort_bcd", {20'd0, a_bcd}, 32'd0);
      chk("abort_b_bcd", {12'd0, b_bcd}, 32'd0);
      chk("abort_c_ovf", {31'd0, c_ovf}, 32'd0);
      @(posedge clk); #1;
      rst_n = 1'b1;
      repeat (12) @(posedge clk);
      #1;
      run_a(8'd42, 20'h042, 1'b0);

      chk("final_queues", qa.size() + qb.size() + qc.size(), 0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
